// File: rtl/ab_bank_arbiter.sv
// Round-robin arbiter that serialises four requesters onto a bank of "ab" cells.
// One command is latched on an IDLE edge and applied to the bank on the following edge.
module ab_bank_arbiter #(
  parameter int unsigned IDX_W = 3,
  parameter int unsigned NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op,
  input  logic [NREQ*IDX_W-1:0]   idx,
  input  logic                    clr,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic [(2**IDX_W)-1:0]   q
);

  localparam int unsigned WIDTH = 2 ** IDX_W;
  localparam int unsigned PTR_W = $clog2(NREQ);
  localparam int unsigned OP_W  = 2;

  localparam logic [OP_W-1:0] OP_HOLD   = 2'b00;
  localparam logic [OP_W-1:0] OP_SET    = 2'b01;
  localparam logic [OP_W-1:0] OP_RESET  = 2'b10;
  localparam logic [OP_W-1:0] OP_TOGGLE = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [IDX_W-1:0] idx;
  } cmd_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  cmd_t             cmd_q, cmd_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] bank_q, bank_d;

  logic             win_found;
  logic [PTR_W-1:0] win_id;
  cmd_t             win_cmd;

  // Round-robin search starting just after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_cmd   = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      int c;
      c = (int'(ptr_q) + k) % int'(NREQ);
      if (!win_found && req[c]) begin
        win_found   = 1'b1;
        win_id      = PTR_W'(c);
        win_cmd.op  = op[OP_W*c +: OP_W];
        win_cmd.idx = idx[IDX_W*c +: IDX_W];
      end
    end
  end

  // Next-state and output logic; clr overrides everything except the pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cmd_d   = cmd_q;
    gnt_d   = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    bank_d  = bank_q;

    if (clr) begin
      bank_d  = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            cmd_d   = win_cmd;
            ptr_d   = win_id;
            gnt_d   = NREQ'(1) << win_id;
            busy_d  = 1'b1;
            state_d = GRANT;
          end
        end
        GRANT: begin
          case (cmd_q.op)
            OP_SET:    bank_d[cmd_q.idx] = 1'b1;
            OP_RESET:  bank_d[cmd_q.idx] = 1'b0;
            OP_TOGGLE: bank_d[cmd_q.idx] = ~bank_q[cmd_q.idx];
            OP_HOLD:   bank_d            = bank_q;
            default:   bank_d            = bank_q;
          endcase
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pointer resets to the last requester so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PTR_W'(NREQ - 1);
      cmd_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cmd_q   <= cmd_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bank_q  <= bank_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign done = done_q;
  assign q    = bank_q;

endmodule

// File: tb/tb_ab_bank_arbiter.sv
// Directed bench for ab_bank_arbiter with hand-computed expectations.
module tb_ab_bank_arbiter;

  localparam int unsigned IDX_W = 3;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 2 ** IDX_W;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [NREQ*IDX_W-1:0] idx;
  logic                  clr;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      q;

  int nchecks = 0;
  int nerrors = 0;

  ab_bank_arbiter #(.IDX_W(IDX_W), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .op    (op),
    .idx   (idx),
    .clr   (clr),
    .gnt   (gnt),
    .busy  (busy),
    .done  (done),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int r, input logic [1:0] o, input logic [IDX_W-1:0] ix);
    op[2*r +: 2]      = o;
    idx[IDX_W*r +: IDX_W] = ix;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] eg, input logic eb,
                           input logic ed, input logic [7:0] eq);
    chk({tag, ".gnt"},  32'(gnt),  32'(eg));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
    chk({tag, ".q"},    32'(q),    32'(eq));
  endtask

  // Single-requester command: grant cycle then apply cycle.
  task automatic run_cmd(input string tag, input int r, input logic [1:0] o,
                         input logic [IDX_W-1:0] ix, input logic [7:0] q_before,
                         input logic [7:0] q_after);
    req = '0;
    req[r] = 1'b1;
    set_cmd(r, o, ix);
    step();
    chk_state({tag, ".grant"}, 4'(1 << r), 1'b1, 1'b0, q_before);
    req = '0;
    step();
    chk_state({tag, ".apply"}, 4'b0000, 1'b0, 1'b1, q_after);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    op    = '0;
    idx   = '0;
    clr   = 1'b0;

    #2;
    chk_state("reset", 4'b0000, 1'b0, 1'b0, 8'h00);
    step();
    rst_n = 1'b1;

    // All four contend, each sets its own bit; expect 0,1,2,3 in order.
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_cmd(i, 2'b01, IDX_W'(i));
    step();
    chk_state("all0.grant", 4'b0001, 1'b1, 1'b0, 8'h00);
    req[0] = 1'b0;
    step();
    chk_state("all0.apply", 4'b0000, 1'b0, 1'b1, 8'h01);
    step();
    chk_state("all1.grant", 4'b0010, 1'b1, 1'b0, 8'h01);
    req[1] = 1'b0;
    step();
    chk_state("all1.apply", 4'b0000, 1'b0, 1'b1, 8'h03);
    step();
    chk_state("all2.grant", 4'b0100, 1'b1, 1'b0, 8'h03);
    req[2] = 1'b0;
    step();
    chk_state("all2.apply", 4'b0000, 1'b0, 1'b1, 8'h07);
    step();
    chk_state("all3.grant", 4'b1000, 1'b1, 1'b0, 8'h07);
    req[3] = 1'b0;
    step();
    chk_state("all3.apply", 4'b0000, 1'b0, 1'b1, 8'h0F);
    step();
    chk_state("all.idle", 4'b0000, 1'b0, 1'b0, 8'h0F);

    // Clear in IDLE.
    clr = 1'b1;
    step();
    chk_state("clr_idle", 4'b0000, 1'b0, 1'b0, 8'h00);
    clr = 1'b0;

    // Single request: set bit 5; op/idx change after latch must not matter.
    req = 4'b0001;
    set_cmd(0, 2'b01, 3'd5);
    step();
    chk_state("single.grant", 4'b0001, 1'b1, 1'b0, 8'h00);
    req = '0;
    set_cmd(0, 2'b10, 3'd1);
    step();
    chk_state("single.apply", 4'b0000, 1'b0, 1'b1, 8'h20);
    step();
    chk("single.done_clr", 32'(done), 32'd0);

    // Requester 1 on bit 2: toggle, toggle, set, hold, reset.
    run_cmd("tog1", 1, 2'b11, 3'd2, 8'h20, 8'h24);
    run_cmd("tog2", 1, 2'b11, 3'd2, 8'h24, 8'h20);
    run_cmd("set",  1, 2'b01, 3'd2, 8'h20, 8'h24);
    run_cmd("hold", 1, 2'b00, 3'd2, 8'h24, 8'h24);
    run_cmd("rst",  1, 2'b10, 3'd2, 8'h24, 8'h20);

    // Asynchronous reset mid-command discards it (bit 6 never set).
    req = 4'b1000;
    set_cmd(3, 2'b01, 3'd6);
    step();
    chk_state("arst.grant", 4'b1000, 1'b1, 1'b0, 8'h20);
    req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("arst.async", 4'b0000, 1'b0, 1'b0, 8'h00);
    #1;
    rst_n = 1'b1;
    step();
    chk_state("arst.after", 4'b0000, 1'b0, 1'b0, 8'h00);

    // Fairness: req0 and req2 held high; pointer restarted at 3.
    req = 4'b0101;
    set_cmd(0, 2'b01, 3'd0);
    set_cmd(2, 2'b01, 3'd1);
    step();
    chk_state("fair1.grant", 4'b0001, 1'b1, 1'b0, 8'h00);
    step();
    chk_state("fair1.apply", 4'b0000, 1'b0, 1'b1, 8'h01);
    step();
    chk_state("fair2.grant", 4'b0100, 1'b1, 1'b0, 8'h01);
    step();
    chk_state("fair2.apply", 4'b0000, 1'b0, 1'b1, 8'h03);
    step();
    chk("fair3.gnt", 32'(gnt), 32'h1);
    step();
    step();
    chk("fair4.gnt", 32'(gnt), 32'h4);
    req = '0;
    step();
    chk_state("fair4.apply", 4'b0000, 1'b0, 1'b1, 8'h03);

    // Build q = 0x0F, then clr on the apply edge of a set-bit-7 command.
    run_cmd("b2", 3, 2'b01, 3'd2, 8'h03, 8'h07);
    run_cmd("b3", 1, 2'b01, 3'd3, 8'h07, 8'h0F);
    req = 4'b0001;
    set_cmd(0, 2'b01, 3'd7);
    step();
    chk_state("clrg.grant", 4'b0001, 1'b1, 1'b0, 8'h0F);
    req = '0;
    clr = 1'b1;
    step();
    chk_state("clrg.apply", 4'b0000, 1'b0, 1'b0, 8'h00);
    clr = 1'b0;
    step();
    chk_state("clrg.after", 4'b0000, 1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/ab_bank_arbiter.md
Name: ab_bank_arbiter

Overview:
- Round-robin arbiter and sequencer for a bank of WIDTH "ab" flip-flop cells.
- Four requesters share the bank. Each request applies one ab operation (hold/set/reset/toggle) to one selected bit.
- The block owns the bank state and exposes it on q.
- One command is granted and applied every two clock cycles.

Parameters:
- IDX_W, 3, width of the bit index. WIDTH = 2**IDX_W bank bits (default 8).
- NREQ, 4, number of requesters. Fixed at 4; the parameter is not meant to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit i belongs to requester i.
- op  input  8  per-requester op {A,B}; requester i uses op[2i+1:2i].
- idx  input  4*IDX_W  per-requester bit index; requester i uses idx[i*IDX_W +: IDX_W].
- clr  input  1  synchronous bank clear; highest priority.
- gnt  output  4  one-hot grant, registered.
- busy  output  1  high while a granted command is pending.
- done  output  1  one-cycle pulse after a command has been applied to q.
- q  output  WIDTH  bank contents.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset, applied immediately when rst_n falls and independent of clk:
  - q = 0, gnt = 0, busy = 0, done = 0.
  - State = IDLE, round-robin pointer ptr = 3, so requester 0 has first priority.
  - A reset mid-command discards the command.
- Op semantics, {A,B}, per ab cell:
  - 00 hold
  - 01 set (q[idx] <= 1)
  - 10 reset (q[idx] <= 0)
  - 11 toggle (q[idx] <= ~q[idx])
- FSM states: IDLE, GRANT.
- IDLE:
  - gnt = 0, busy = 0.
  - At a rising edge with req != 0 and clr = 0:
    - Winner w = first requester with req set, searching ptr+1, ptr+2, ptr+3, ptr+4, all modulo 4.
    - Latch op[w] and idx[w] into the command register.
    - ptr <= w; gnt <= one-hot(w); busy <= 1; go to GRANT.
  - At a rising edge with req = 0, stay in IDLE.
- GRANT:
  - gnt is held for exactly this one cycle.
  - At the next rising edge:
    - Apply the latched command to q.
    - gnt <= 0, busy <= 0, done <= 1, go to IDLE.
  - No arbitration occurs on this edge.
- Requester protocol:
  - Hold req, op and idx stable until gnt[i] is seen.
  - Deassert req during the GRANT cycle.
  - A req still high at the next IDLE edge is a new request.
  - op/idx changes after the latch edge do not affect the pending command.
- done:
  - High for exactly the one cycle after the apply edge.
  - Pulses for hold ops too.
  - Cleared on every other edge.
- clr = 1 at a rising edge:
  - q <= 0, state <= IDLE, gnt <= 0, busy <= 0, done <= 0.
  - Any pending command is discarded; ptr is unchanged.
  - No arbitration occurs on that edge.
- Latency:
  - Request sampled at edge k; gnt visible after edge k.
  - q updated at edge k+1; done high between edges k+1 and k+2.
- Throughput: at most one command per 2 cycles.
- Fairness: a continuously asserted requester waits at most 3 other grants.
- idx is always in range (WIDTH = 2**IDX_W), so no bounds check is needed.
- Only the command path writes q, apart from clr and reset.

Test Plan:
- Reset: drive commands, then pull rst_n low between edges -> q = 0x00, gnt = 0, busy = 0 at once, before any clk edge. After release, the first grant goes to requester 0 if all request.
- Single request: req = 0001, op0 = 01, idx0 = 5 at edge k -> gnt = 0001 and busy = 1 after k. q = 0x20 after k+1. done = 1 for one cycle.
- All contend: req = 1111 at the first IDLE edge. Each requester i uses op = 01, idx = i and drops req when granted -> grants in order 0001, 0010, 0100, 1000 on alternate cycles. Final q = 0x0F. Four done pulses.
- Ops on bit 2 from requester 1 in sequence toggle, toggle, set, hold, reset -> q[2] = 1, 0, 1, 1, 0. done pulses on all five.
- Fairness: req0 and req2 held high continuously -> gnt sequence 0001, 0100, 0001, 0100 with ptr alternating.
- clr during GRANT: set idx 7 granted, clr = 1 at the apply edge with q = 0x0F -> q = 0x00, gnt = 0, done stays 0. Bit 7 is never set.
